// File: rtl/irq_vector_pkg.sv
// Shared types and helpers for the interrupt vector controller:
// service state, default vector addresses and the priority encoder.
package irq_vector_pkg;

    typedef enum logic [1:0] {
        ST_RST,
        ST_IDLE,
        ST_TAKEN
    } state_t;

    localparam logic [15:0] DEF_VEC_BASE = 16'hFFE0;
    localparam logic [15:0] DEF_RST_VEC  = 16'hFFFC;

    // NMI wins outright; otherwise the lowest eligible index wins.
    function automatic logic [3:0] prio_encode(input logic [15:0] elig,
                                               input logic [3:0]  nmi);
        logic [3:0] win;
        win = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (elig[i]) win = 4'(i);
        end
        if (elig[nmi]) win = nmi;
        return win;
    endfunction

endpackage

// File: rtl/irq_src_latch.sv
// One interrupt source: rising-edge detector or level follower feeding a
// pending flop. Edge history keeps tracking src even while detection is off.
module irq_src_latch
    import irq_vector_pkg::*;
#(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ce,
    input  logic i_src,
    input  logic i_edge_en,
    input  logic i_clr,
    output logic o_pending
);

    logic r_hist;
    logic r_pend;
    logic w_rise;
    logic w_next;

    // A fresh edge beats a same-cycle clear so the new request is not lost.
    assign w_rise = i_src & ~r_hist & i_edge_en;
    assign w_next = EDGE ? (w_rise | (r_pend & ~i_clr)) : i_src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= 1'b0;
            r_pend <= 1'b0;
        end else if (i_ce) begin
            r_hist <= i_src;
            r_pend <= w_next;
        end
    end

    assign o_pending = r_pend;

endmodule

// File: rtl/irq_vector_ctrl.sv
// Interrupt controller for the 6502-class core: per-source pending latches,
// masking and fixed priority, plus the RST/IDLE/TAKEN service sequencer.
module irq_vector_ctrl
    import irq_vector_pkg::*;
#(
    parameter int                 NUM_SRC   = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MODE = 4'b0001,
    parameter int                 NMI_SRC   = 0,
    parameter logic [15:0]        VEC_BASE  = DEF_VEC_BASE,
    parameter logic [15:0]        RST_VEC   = DEF_RST_VEC,
    localparam int                ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [NUM_SRC-1:0] src,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               i_flag,
    input  logic               poll,
    input  logic               ack,
    output logic               got_int,
    output logic               is_reset,
    output logic [ID_W-1:0]    active_id,
    output logic [15:0]        vector,
    output logic [NUM_SRC-1:0] pending
);

    state_t             r_state;
    logic [NUM_SRC-1:0] w_pend;
    logic [NUM_SRC-1:0] w_elig;
    logic [ID_W-1:0]    w_win;
    logic               w_ack_taken;

    assign w_ack_taken = ce & ack & (r_state == ST_TAKEN);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        irq_src_latch #(
            .EDGE(EDGE_MODE[gi])
        ) u_src (
            .clk      (clk),
            .reset    (reset),
            .i_ce     (ce),
            .i_src    (src[gi]),
            .i_edge_en(r_state != ST_RST),
            .i_clr    (w_ack_taken && (active_id == ID_W'(gi))),
            .o_pending(w_pend[gi])
        );

        assign w_elig[gi] = (gi == NMI_SRC) ? w_pend[gi]
                                            : (w_pend[gi] & mask[gi] & ~i_flag);
    end

    assign w_win   = ID_W'(prio_encode(16'(w_elig), 4'(NMI_SRC)));
    assign pending = w_pend;

    // Once TAKEN, id and vector stay frozen until the CPU acks the fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RST;
            got_int   <= 1'b1;
            is_reset  <= 1'b1;
            vector    <= RST_VEC;
            active_id <= '0;
        end else if (ce) begin
            case (r_state)
                ST_RST: begin
                    if (ack) begin
                        r_state  <= ST_IDLE;
                        got_int  <= 1'b0;
                        is_reset <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (poll && (|w_elig)) begin
                        r_state   <= ST_TAKEN;
                        got_int   <= 1'b1;
                        active_id <= w_win;
                        vector    <= VEC_BASE + 16'({w_win, 1'b0});
                    end
                end
                ST_TAKEN: begin
                    if (ack) begin
                        r_state <= ST_IDLE;
                        got_int <= 1'b0;
                    end
                end
                default: r_state <= ST_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl with a queue of expected output values.
module tb_irq_vector_ctrl;

    logic       clk;
    logic       reset;
    logic       ce;
    logic [3:0] src;
    logic [3:0] mask;
    logic       i_flag;
    logic       poll;
    logic       ack;
    logic       got_int;
    logic       is_reset;
    logic [1:0] active_id;
    logic [15:0] vector;
    logic [3:0] pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    irq_vector_ctrl #(
        .NUM_SRC  (4),
        .EDGE_MODE(4'b0001),
        .NMI_SRC  (0),
        .VEC_BASE (16'hFFE0),
        .RST_VEC  (16'hFFFC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .src      (src),
        .mask     (mask),
        .i_flag   (i_flag),
        .poll     (poll),
        .ack      (ack),
        .got_int  (got_int),
        .is_reset (is_reset),
        .active_id(active_id),
        .vector   (vector),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; src = 4'b0000; mask = 4'b0000;
        i_flag = 1'b0; poll = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        expect_val("rst_got_int", 32'd1); expect_val("rst_is_reset", 32'd1);
        expect_val("rst_vector", 32'hFFFC); expect_val("rst_active_id", 32'd0);
        expect_val("rst_pending", 32'd0);
        chk(32'(got_int)); chk(32'(is_reset)); chk(32'(vector));
        chk(32'(active_id)); chk(32'(pending));

        // NMI edge while still in RST is ignored
        src = 4'b0001;
        expect_val("rst_edge_pending", 32'd0); expect_val("rst_edge_got_int", 32'd1);
        step();
        chk(32'(pending)); chk(32'(got_int));

        ack = 1'b1;
        expect_val("rst_ack_got_int", 32'd0); expect_val("rst_ack_is_reset", 32'd0);
        expect_val("rst_ack_pending", 32'd0);
        step();
        chk(32'(got_int)); chk(32'(is_reset)); chk(32'(pending));
        ack = 1'b0; src = 4'b0000;
        step();

        // Level source 1
        src = 4'b0010; mask = 4'b0010;
        expect_val("lvl_pending", 32'h2);
        step();
        chk(32'(pending));
        i_flag = 1'b1; poll = 1'b1;
        expect_val("lvl_iflag_no_take", 32'd0);
        step();
        chk(32'(got_int));
        i_flag = 1'b0;
        expect_val("lvl_got_int", 32'd1); expect_val("lvl_active_id", 32'd1);
        expect_val("lvl_vector", 32'hFFE2);
        step();
        chk(32'(got_int)); chk(32'(active_id)); chk(32'(vector));
        poll = 1'b0; ack = 1'b1;
        expect_val("lvl_ack_got_int", 32'd0);
        step();
        chk(32'(got_int));
        ack = 1'b0; src = 4'b0000;
        expect_val("lvl_drop_pending", 32'd0);
        step();
        chk(32'(pending));

        // NMI edge + level src2 with i_flag set
        src = 4'b0101; mask = 4'b0100; i_flag = 1'b1;
        expect_val("nmi_pending", 32'h5);
        step();
        chk(32'(pending));
        poll = 1'b1;
        expect_val("nmi_got_int", 32'd1); expect_val("nmi_active_id", 32'd0);
        expect_val("nmi_vector", 32'hFFE0);
        step();
        chk(32'(got_int)); chk(32'(active_id)); chk(32'(vector));
        poll = 1'b0; ack = 1'b1;
        expect_val("nmi_ack_got_int", 32'd0); expect_val("nmi_ack_pending", 32'h4);
        step();
        chk(32'(got_int)); chk(32'(pending));
        ack = 1'b0; poll = 1'b1;
        expect_val("nmi_held_no_retake", 32'd0);
        step();
        chk(32'(got_int));
        i_flag = 1'b0;
        expect_val("src2_got_int", 32'd1); expect_val("src2_active_id", 32'd2);
        expect_val("src2_vector", 32'hFFE4);
        step();
        chk(32'(got_int)); chk(32'(active_id)); chk(32'(vector));
        poll = 1'b0; ack = 1'b1;
        step();
        ack = 1'b0; src = 4'b0000; mask = 4'b0000;
        step();

        // Second edge in the same cycle as ack
        src = 4'b0001;
        step();
        poll = 1'b1;
        expect_val("dbl_got_int", 32'd1);
        step();
        chk(32'(got_int));
        poll = 1'b0; src = 4'b0000;
        step();
        src = 4'b0001; ack = 1'b1;
        expect_val("dbl_ack_got_int", 32'd0); expect_val("dbl_ack_pending", 32'h1);
        step();
        chk(32'(got_int)); chk(32'(pending));
        ack = 1'b0; poll = 1'b1;
        expect_val("dbl_retake_got_int", 32'd1); expect_val("dbl_retake_id", 32'd0);
        step();
        chk(32'(got_int)); chk(32'(active_id));
        poll = 1'b0; ack = 1'b1;
        expect_val("dbl_clear_pending", 32'd0);
        step();
        chk(32'(pending));
        ack = 1'b0; src = 4'b0000;
        step();

        // Edge on the poll cycle waits for the next poll
        src = 4'b0001; poll = 1'b1;
        expect_val("pe_no_take", 32'd0); expect_val("pe_pending", 32'h1);
        step();
        chk(32'(got_int)); chk(32'(pending));
        expect_val("pe_take", 32'd1);
        step();
        chk(32'(got_int));
        poll = 1'b0; ack = 1'b1;
        step();
        ack = 1'b0; src = 4'b0000;
        step();

        // ce low mid-TAKEN holds everything
        src = 4'b0010; mask = 4'b0010;
        step();
        poll = 1'b1;
        step();
        poll = 1'b0; ce = 1'b0; src = 4'b0000; mask = 4'b0000; ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            expect_val("ce_got_int", 32'd1); expect_val("ce_active_id", 32'd1);
            expect_val("ce_vector", 32'hFFE2); expect_val("ce_pending", 32'h2);
            step();
            chk(32'(got_int)); chk(32'(active_id)); chk(32'(vector)); chk(32'(pending));
        end

        // Reset during TAKEN
        ce = 1'b1; ack = 1'b0; src = 4'b0011; mask = 4'b0010;
        expect_val("pre_rst_pending", 32'h3); expect_val("pre_rst_got_int", 32'd1);
        step();
        chk(32'(pending)); chk(32'(got_int));
        expect_val("mid_rst_got_int", 32'd1); expect_val("mid_rst_vector", 32'hFFFC);
        expect_val("mid_rst_pending", 32'd0); expect_val("mid_rst_is_reset", 32'd1);
        expect_val("mid_rst_active_id", 32'd0);
        #2 reset = 1'b1;
        #1;
        chk(32'(got_int)); chk(32'(vector)); chk(32'(pending));
        chk(32'(is_reset)); chk(32'(active_id));
        @(negedge clk);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
